// File: rtl/register_file.sv
// 16 x 16 general-purpose register file: two combinational read ports, one clocked write port, R0 reads zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  wr_en;

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_fwd;
    logic              rt_fwd;

    // An unknown RD compares as false, so it can never enable a write.
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (RegWrite && (RD == ADDR_W'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rs_data = (RS == '0) ? '0 : regs_q[RS];
        rt_data = (RT == '0) ? '0 : regs_q[RT];
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    always_comb begin
        rs_fwd = RegWrite && (RD != '0) && (RD == RS);
        rt_fwd = RegWrite && (RD != '0) && (RD == RT);
    end
`else
    always_comb begin
        rs_fwd = 1'b0;
        rt_fwd = 1'b0;
    end
`endif

    // Reset forces zero on the outputs so forwarding cannot leak WriteData while Reset_n is low.
    always_comb begin
        if (!Reset_n) begin
            ReadRS = '0;
            ReadRT = '0;
        end else begin
            ReadRS = rs_fwd ? WriteData : rs_data;
            ReadRT = rt_fwd ? WriteData : rt_data;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, basic write/read, write enable, R0, same-cycle read/write, full sweep.
`timescale 1ns/1ps
module tb_register_file;

    logic        Clock;
    logic        Reset_n;
    logic [3:0]  RS;
    logic [3:0]  RT;
    logic [3:0]  RD;
    logic [15:0] WriteData;
    logic        RegWrite;
    logic [15:0] ReadRS;
    logic [15:0] ReadRT;

    int checks = 0;
    int errors = 0;

    register_file #(.DATA_W(16), .ADDR_W(4)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        RD        = a;
        WriteData = d;
        RegWrite  = 1'b1;
        @(posedge Clock);
        #1;
        RegWrite  = 1'b0;
    endtask

    initial begin
        logic [15:0] e_rs;
        logic [15:0] e_rt;

        Reset_n   = 1'b0;
        RS        = 4'd0;
        RT        = 4'd0;
        RD        = 4'd0;
        WriteData = 16'h0000;
        RegWrite  = 1'b0;

        #12;
        RS = 4'd7;
        RT = 4'd15;
        #1;
        check("reset_rs", ReadRS, 16'h0000);
        check("reset_rt", ReadRT, 16'h0000);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        // Async reset pulse clears a stored value without any clock edge.
        wr(4'd3, 16'hFFFF);
        RS = 4'd3;
        RT = 4'd3;
        #1;
        check("pre_reset_r3", ReadRS, 16'hFFFF);
        Reset_n = 1'b0;
        #1;
        check("async_reset_rs", ReadRS, 16'h0000);
        check("async_reset_rt", ReadRT, 16'h0000);
        RD        = 4'd4;
        WriteData = 16'hAAAA;
        RegWrite  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            RS = 4'(i);
            RT = 4'(15 - i);
            #1;
            check($sformatf("reset_sweep_rs%0d", i), ReadRS, 16'h0000);
            check($sformatf("reset_sweep_rt%0d", 15 - i), ReadRT, 16'h0000);
        end
        RegWrite = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        RS = 4'd3;
        RT = 4'd4;
        #1;
        check("r3_cleared", ReadRS, 16'h0000);
        check("write_in_reset_ignored", ReadRT, 16'h0000);
        @(posedge Clock);
        #1;

        wr(4'd8, 16'd5);
        wr(4'd9, 16'd7);
        RS = 4'd8;
        RT = 4'd9;
        #1;
        check("basic_r8", ReadRS, 16'd5);
        check("basic_r9", ReadRT, 16'd7);

        RD        = 4'd8;
        WriteData = 16'hABCD;
        RegWrite  = 1'b0;
        @(posedge Clock);
        #1;
        check("we_low_r8", ReadRS, 16'd5);

        wr(4'd0, 16'h1234);
        RS = 4'd0;
        RT = 4'd0;
        #1;
        check("r0_rs", ReadRS, 16'h0000);
        check("r0_rt", ReadRT, 16'h0000);

        // A write targeting R0 never forwards, even with bypass built in.
        RD        = 4'd0;
        WriteData = 16'h5A5A;
        RegWrite  = 1'b1;
        #1;
        check("r0_no_fwd", ReadRS, 16'h0000);
        RegWrite = 1'b0;
        @(posedge Clock);
        #1;

        wr(4'd5, 16'h0011);
        RS        = 4'd5;
        RT        = 4'd5;
        RD        = 4'd5;
        WriteData = 16'h00FF;
        RegWrite  = 1'b1;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("same_cycle_rs_before", ReadRS, 16'h00FF);
        check("same_cycle_rt_before", ReadRT, 16'h00FF);
`else
        check("same_cycle_rs_before", ReadRS, 16'h0011);
        check("same_cycle_rt_before", ReadRT, 16'h0011);
`endif
        @(posedge Clock);
        #1;
        RegWrite = 1'b0;
        check("same_cycle_rs_after", ReadRS, 16'h00FF);
        check("same_cycle_rt_after", ReadRT, 16'h00FF);

        for (int i = 1; i < 16; i++) begin
            wr(4'(i), 16'(i) * 16'h1111);
        end
        for (int i = 0; i < 16; i++) begin
            RS = 4'(i);
            RT = 4'(15 - i);
            #1;
            e_rs = 16'(i) * 16'h1111;
            e_rt = 16'(15 - i) * 16'h1111;
            check($sformatf("sweep_rs%0d", i), ReadRS, e_rs);
            check($sformatf("sweep_rt%0d", 15 - i), ReadRT, e_rt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 16-entry x 16-bit general-purpose register file for the 16-bit CPU datapath.
- Two asynchronous (combinational) read ports, RS and RT, and one synchronous write port, RD.
- Sits between instruction decode (register addresses) and the ALU and writeback stage.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 16: width of each register and of the data ports.
- ADDR_W, 4: address width. Register count is 2**ADDR_W, which is 16 by default.

Ports:
- Clock, input, 1: system clock. All writes occur on the rising edge.
- Reset_n, input, 1: asynchronous, active-low reset. Clears all registers.
- RS, input, ADDR_W: read address for port RS.
- RT, input, ADDR_W: read address for port RT.
- RD, input, ADDR_W: write address.
- WriteData, input, DATA_W: data to be written.
- RegWrite, input, 1: write enable, active high.
- ReadRS, output, DATA_W: contents of register RS.
- ReadRT, output, DATA_W: contents of register RT.

Behaviour:
- Reset:
  - Reset_n low asynchronously forces all 16 registers to 0, independent of Clock.
  - While Reset_n is low, ReadRS and ReadRT read 0 and writes are ignored.
  - Deassertion takes effect at the next rising Clock edge.
- Write:
  - On a rising edge of Clock with Reset_n high and RegWrite=1, register[RD] <= WriteData.
  - With RegWrite=0, no register changes.
  - Single cycle; the new value is visible on the read ports after that edge.
- Register 0:
  - Writes to RD=0 are discarded.
  - Reading address 0 always returns 0.
- Read:
  - ReadRS = register[RS] and ReadRT = register[RT], purely combinational with zero-cycle latency.
  - RS and RT are fully independent and may be equal; both ports then return the same value.
- Simultaneous read and write to the same address in one cycle (bypass disabled):
  - Read ports return the old value until the rising edge.
  - After the edge they return the new value.
- Unknown or X read addresses must not corrupt stored state; outputs may be X.
- Only the addressed register changes on a write. All others hold.
- Data is stored and returned unmodified at the full DATA_W width. No sign handling.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- When defined:
  - If RegWrite=1, RD!=0 and RD equals RS (or RT), the corresponding read port combinationally returns WriteData in the same cycle, before the clock edge.
  - Both ports may bypass simultaneously.
  - Reset_n low overrides the bypass and outputs read 0.
- When undefined:
  - No forwarding. Read ports reflect only stored register contents, as described in Behaviour.
- Storage and write timing are identical in both builds.

Test Plan:
- Reset: pulse Reset_n low mid-cycle, with no Clock edge -> ReadRS=ReadRT=0 immediately for every address 0..15; a prior write of 16'hFFFF to R3 is cleared to 0.
- Basic write and read:
  - Write RD=8, WriteData=5, RegWrite=1, rising edge.
  - Then write RD=9, WriteData=7, rising edge.
  - Set RegWrite=0, RS=8, RT=9 -> ReadRS=5, ReadRT=7.
- Write enable low: RegWrite=0, RD=8, WriteData=16'hABCD, rising edge -> R8 still reads 5.
- R0 hardwired: RegWrite=1, RD=0, WriteData=16'h1234, rising edge -> RS=0 reads 0.
- Same-cycle read/write, bypass disabled:
  - R5=16'h0011. Drive RS=5, RD=5, WriteData=16'h00FF, RegWrite=1.
  - Before the edge, ReadRS=16'h0011; after the edge, 16'h00FF.
  - With REGFILE_WRITE_BYPASS_EN defined, ReadRS=16'h00FF before the edge.
- Full sweep:
  - Write register[i]=i*16'h1111 for i=1..15.
  - Read every pair (RS=i, RT=15-i) and check both values, with R0 reading 0.
